// File: rtl/fetch_queue.sv
// Instruction fetch queue: a PC generator feeding a circular buffer of {pc, instr} entries.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue forward the fetch straight to the consumer.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic [31:0]              im_rdata,
    input  logic                     out_ready,
    output logic [31:0]              im_addr,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic bypass_act;
    logic pop;
    logic push;
    logic store_push;
    logic store_pop;

    logic unused_rp;
    assign unused_rp = ^redirect_pc[1:0];

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == (AW+1)'(DEPTH));
        bypass_act = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_act = empty && en && !redirect && !reset;
`endif
        out_valid = !empty || bypass_act;
        out_pc    = 32'h0;
        out_instr = 32'h0;
        if (!empty) begin
            out_pc    = pc_mem[head_q];
            out_instr = instr_mem[head_q];
        end else if (bypass_act) begin
            out_pc    = pc_q;
            out_instr = im_rdata;
        end

        pop  = out_valid && out_ready && !redirect;
        push = en && !redirect && (!full || pop);
        // A bypassed fetch that is consumed at once never occupies a slot.
        store_push = push && !(bypass_act && pop);
        store_pop  = pop && !empty;

        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push)
                pc_d = pc_q + 32'd4;
            if (store_push)
                tail_d = tail_q + 1'b1;
            if (store_pop)
                head_d = head_q + 1'b1;
            case ({store_push, store_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        im_addr = pc_q;
        count   = count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store_push && !reset) begin
            pc_mem[tail_q]    <= pc_q;
            instr_mem[tail_q] <= im_rdata;
        end
    end

endmodule
